// File: rtl/num_input_fifo_if.sv
// rtl/num_input_fifo_if.sv - delivery and status bundle between num_input_fifo and the CPU
interface num_input_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic             block;
   logic [WIDTH-1:0] num_in;
   logic             num_clk;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             overflow;

   modport master (input block, output num_in, num_clk, count, full, empty, overflow);
   modport slave  (output block, input num_in, num_clk, count, full, empty, overflow);
endinterface

// File: rtl/num_input_fifo.sv
// rtl/num_input_fifo.sv - debounced button capture of switch values into a FIFO
// Queued values are strobed to the CPU one per block request.
module num_input_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int DEBOUNCE = 4
) (
   input  logic                   clkin,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       sw_in,
   input  logic                   btn,
   num_input_fifo_if.master       cpu
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int DBW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sw_meta_q, sw_s_q;
   logic             btn_meta_q, btn_s_q;
   logic [DBW-1:0]   db_cnt_q, db_cnt_d;
   logic             btn_clean_q, btn_clean_d;
   logic             btn_prev_q;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] num_in_q, num_in_d;
   logic             num_clk_q, num_clk_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push, pop, push_ok;

   // The level only flips after DEBOUNCE consecutive disagreeing samples.
   always_comb begin
      db_cnt_d    = '0;
      btn_clean_d = btn_clean_q;
      if (btn_s_q != btn_clean_q) begin
         if (db_cnt_q == DBW'(DEBOUNCE - 1)) begin
            btn_clean_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
         end
      end
   end

   assign push    = btn_clean_q & ~btn_prev_q;
   assign pop     = (state_q == PULSE);
   assign push_ok = push & (~full_q | pop);

   always_comb begin
      wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push_ok && !pop) count_d = count_q + CW'(1);
      if (!push_ok && pop) count_d = count_q - CW'(1);
      full_d     = (count_d == CW'(DEPTH));
      empty_d    = (count_d == '0);
      overflow_d = overflow_q | (push & full_q & ~pop);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cpu.block && !empty_q) state_d = PULSE;
         PULSE:   state_d = WAIT;
         WAIT:    if (!cpu.block) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      num_in_d  = num_in_q;
      num_clk_d = 1'b0;
      if (state_q == IDLE && cpu.block && !empty_q) begin
         num_in_d  = mem_q[rd_ptr_q];
         num_clk_d = 1'b1;
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         sw_meta_q   <= '0;
         sw_s_q      <= '0;
         btn_meta_q  <= 1'b0;
         btn_s_q     <= 1'b0;
         db_cnt_q    <= '0;
         btn_clean_q <= 1'b0;
         btn_prev_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         num_in_q    <= '0;
         num_clk_q   <= 1'b0;
      end else begin
         sw_meta_q   <= sw_in;
         sw_s_q      <= sw_meta_q;
         btn_meta_q  <= btn;
         btn_s_q     <= btn_meta_q;
         db_cnt_q    <= db_cnt_d;
         btn_clean_q <= btn_clean_d;
         btn_prev_q  <= btn_clean_q;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         num_in_q    <= num_in_d;
         num_clk_q   <= num_clk_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clkin) begin
      if (push_ok) mem_q[wr_ptr_q] <= sw_s_q;
   end

   assign cpu.num_in   = num_in_q;
   assign cpu.num_clk  = num_clk_q;
   assign cpu.count    = count_q;
   assign cpu.full     = full_q;
   assign cpu.empty    = empty_q;
   assign cpu.overflow = overflow_q;
endmodule

// File: tb/tb_num_input_fifo.sv
// tb/tb_num_input_fifo.sv - bench for num_input_fifo against a queue model
module tb_num_input_fifo;
   localparam int WIDTH    = 8;
   localparam int DEPTH    = 4;
   localparam int DEBOUNCE = 4;

   logic             clkin = 1'b0;
   logic             reset = 1'b1;
   logic [WIDTH-1:0] sw_in = '0;
   logic             btn   = 1'b0;

   num_input_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) cpu ();

   num_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE)) dut (
      .clkin (clkin),
      .reset (reset),
      .sw_in (sw_in),
      .btn   (btn),
      .cpu   (cpu.master)
   );

   always #5 clkin = ~clkin;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [WIDTH-1:0] model_q [$];
   bit               model_ovf;

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(string tag);
      chk({tag, "_count"}, 32'(cpu.count), model_q.size());
      chk({tag, "_full"}, 32'(cpu.full), 32'(model_q.size() == DEPTH));
      chk({tag, "_empty"}, 32'(cpu.empty), 32'(model_q.size() == 0));
      chk({tag, "_overflow"}, 32'(cpu.overflow), 32'(model_ovf));
   endtask

   task automatic model_push(logic [WIDTH-1:0] v);
      if (model_q.size() < DEPTH) model_q.push_back(v);
      else                        model_ovf = 1'b1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
      step();
      chk("reset_num_in", 32'(cpu.num_in), 0);
      chk("reset_num_clk", 32'(cpu.num_clk), 0);
      check_status("reset");
   endtask

   task automatic press(logic [WIDTH-1:0] v);
      sw_in = v;
      btn   = 1'b1;
      repeat (DEBOUNCE + 3) step();
      model_push(v);
      check_status("press");
      btn = 1'b0;
      repeat (DEBOUNCE + 4) step();
   endtask

   task automatic deliver(int win);
      logic [WIDTH-1:0] exp_v;
      int               pulses;
      exp_v     = model_q.pop_front();
      cpu.block = 1'b1;
      step();
      chk("deliver_strobe", 32'(cpu.num_clk), 1);
      chk("deliver_value", 32'(cpu.num_in), 32'(exp_v));
      step();
      chk("deliver_strobe_end", 32'(cpu.num_clk), 0);
      chk("deliver_count", 32'(cpu.count), model_q.size());
      pulses = 0;
      repeat (win - 2) begin
         step();
         if (cpu.num_clk) pulses++;
      end
      chk("one_per_request", pulses, 0);
      cpu.block = 1'b0;
      repeat (2) step();
      chk("num_in_hold", 32'(cpu.num_in), 32'(exp_v));
   endtask

   initial begin
      logic [WIDTH-1:0] vnew;
      logic [WIDTH-1:0] exp_v;
      int               pulses;
      cpu.block = 1'b0;
      model_ovf = 1'b0;

      // Reset, single press with exact latency, delivery
      apply_reset();
      sw_in = 8'h2A;
      btn   = 1'b1;
      repeat (6) step();
      chk("latency_edge6", 32'(cpu.count), 0);
      step();
      chk("latency_edge7", 32'(cpu.count), 1);
      model_push(8'h2A);
      repeat (3) step();
      btn = 1'b0;
      repeat (DEBOUNCE + 4) step();
      check_status("single");
      deliver(5);
      check_status("single_drained");

      // Empty FIFO with block high: no strobe
      cpu.block = 1'b1;
      pulses = 0;
      repeat (8) begin
         step();
         if (cpu.num_clk) pulses++;
      end
      cpu.block = 1'b0;
      step();
      chk("empty_no_strobe", pulses, 0);

      // Bounce rejection
      sw_in = 8'h5C;
      btn = 1'b1; step();
      btn = 1'b0; step();
      btn = 1'b1; step();
      btn = 1'b0; step();
      btn = 1'b1;
      repeat (2 * DEBOUNCE + 6) step();
      model_push(8'h5C);
      check_status("bounce");
      btn = 1'b0;
      repeat (DEBOUNCE + 4) step();
      deliver(4);

      // Random short glitches never push
      for (int i = 0; i < 6; i++) begin
         sw_in = WIDTH'($urandom);
         btn   = 1'b1;
         repeat ($urandom_range(1, DEBOUNCE - 1)) step();
         btn = 1'b0;
         repeat (DEBOUNCE + 4) step();
      end
      check_status("glitch");

      // Queue ahead, one value per request
      press(8'h01);
      press(8'h02);
      press(8'h03);
      repeat (3) deliver(5);
      check_status("queue_ahead");

      // Full and sticky overflow
      apply_reset();
      for (int v = 8'h10; v <= 8'h14; v++) press(WIDTH'(v));
      check_status("overflow");
      repeat (DEPTH) deliver(4);
      check_status("overflow_drained");

      // Push and pop on the same edge while full
      apply_reset();
      repeat (DEPTH) press(WIDTH'($urandom));
      vnew  = WIDTH'($urandom);
      sw_in = vnew;
      btn   = 1'b1;
      repeat (DEBOUNCE + 1) step();
      cpu.block = 1'b1;
      step();
      exp_v = model_q.pop_front();
      chk("simul_strobe", 32'(cpu.num_clk), 1);
      chk("simul_value", 32'(cpu.num_in), 32'(exp_v));
      step();
      model_push(vnew);
      check_status("simul");
      cpu.block = 1'b0;
      btn       = 1'b0;
      repeat (DEBOUNCE + 4) step();
      repeat (DEPTH) deliver(3);
      check_status("simul_drained");

      // Reset while strobing
      apply_reset();
      press(8'h77);
      cpu.block = 1'b1;
      step();
      chk("pulse_before_reset", 32'(cpu.num_clk), 1);
      reset = 1'b1;
      #1;
      chk("async_num_clk", 32'(cpu.num_clk), 0);
      chk("async_count", 32'(cpu.count), 0);
      chk("async_num_in", 32'(cpu.num_in), 0);
      step();
      reset = 1'b0;
      model_q.delete();
      model_ovf = 1'b0;
      pulses = 0;
      repeat (20) begin
         step();
         if (cpu.num_clk) pulses++;
      end
      chk("no_pulse_after_reset", pulses, 0);
      sw_in = 8'h99;
      btn   = 1'b1;
      repeat (DEBOUNCE + 3) step();
      chk("fresh_press_count", 32'(cpu.count), 1);
      step();
      chk("fresh_press_strobe", 32'(cpu.num_clk), 1);
      chk("fresh_press_value", 32'(cpu.num_in), 32'h99);
      cpu.block = 1'b0;
      btn       = 1'b0;
      repeat (DEBOUNCE + 4) step();
      check_status("fresh_press_done");

      // Random mix of presses and deliveries
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0 && model_q.size() > 0) deliver($urandom_range(3, 7));
         else press(WIDTH'($urandom));
      end
      while (model_q.size() > 0) deliver(3);
      check_status("random_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/num_input_fifo.md
# num_input_fifo

Upstream input stage for the `control` CPU's number port. It debounces the raw pushbutton, captures the synchronized switch value on each clean press into a small FIFO, and delivers queued values to the CPU. Delivery happens over the `num_in`/`num_clk` pair whenever the CPU signals `block` (stalled waiting for input). Presses made before the program asks for a number are therefore queued instead of lost.

## Interface
Parameters:
- WIDTH, 8, data width; matches the CPU `num_in` width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DEBOUNCE, 4, consecutive stable cycles required before the debounced button level changes; minimum 1.

Ports:
- clkin  in  1  system clock; one clock domain only.
- reset  in  1  asynchronous, active-high; clears all state.
- sw_in  in  WIDTH  raw switch value, asynchronous to `clkin`.
- btn  in  1  raw pushbutton, asynchronous and bouncing.
- block  in  1  from `control`; high while the CPU waits for a number.
- num_in  out  WIDTH  value presented to the CPU; registered.
- num_clk  out  1  one-cycle delivery strobe to the CPU; registered.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  high when count == DEPTH.
- empty  out  1  high when count == 0.
- overflow  out  1  sticky; set when a press is dropped because the FIFO is full.

## Operation
Input path:
- `btn` and `sw_in` each pass through a two-flop synchronizer, giving `btn_s` and `sw_s`.
- Debounce counter:
  - Increments on every cycle where `btn_s` differs from `btn_clean`.
  - Clears on every cycle where they are equal.
  - When it reaches DEBOUNCE, `btn_clean` takes the value of `btn_s` and the counter clears.
- A registered rising-edge detect on `btn_clean` produces `push`, exactly one cycle per press.
- On `push`, `sw_s` is written at `wr_ptr`, `wr_ptr` increments modulo DEPTH, and count increments.
- Push while full with no pop in the same cycle: the value is dropped, `overflow` is set, and pointers and count are unchanged.

Delivery FSM (states IDLE, PULSE, WAIT):
- IDLE:
  - Condition: `block` = 1 and `empty` = 0.
  - Action: `num_in` ← FIFO[`rd_ptr`], `num_clk` ← 1, go to PULSE.
  - Otherwise stay in IDLE.
- PULSE:
  - `num_clk` ← 0.
  - Pop: `rd_ptr` increments modulo DEPTH and count decrements.
  - Go to WAIT.
  - This path is unconditional; a value that has been strobed counts as delivered even if `block` falls during PULSE.
- WAIT:
  - Stay in WAIT while `block` = 1.
  - When `block` = 0 is sampled, go to IDLE.
  - This guarantees at most one value per CPU input request.

Output behaviour:
- `num_in` holds the last delivered value until the next delivery.

Simultaneous events:
- Push and pop in the same cycle: both take effect and count is unchanged.
- Push and pop in the same cycle while full: the push is accepted with no overflow.
- Push into an empty FIFO: the new value becomes visible to IDLE from the next cycle.

## Timing
- Reset values:
  - Outputs: `num_in` = 0, `num_clk` = 0, count = 0, `full` = 0, `empty` = 1, `overflow` = 0.
  - Internal state: FSM = IDLE, pointers = 0, `btn_clean` = 0, debounce counter = 0.
- Press latency: the edge that first samples `btn` = 1 is edge 1; with `btn` held steady, count increments at edge DEBOUNCE+3.
- Release latency is identical, but a release produces no push.
- Glitch rejection: any `btn_s` pulse shorter than DEBOUNCE cycles produces no push.
- Delivery latency: if `block` rises with the FIFO non-empty and is sampled at edge k, then `num_clk` is high for exactly the cycle between edges k and k+1, and count decrements at edge k+1.
- Minimum spacing: consecutive `num_clk` pulses are at least 3 cycles apart (PULSE, WAIT with `block` low, IDLE).
- `full`, `empty` and count are registered and update on the same edge as the pointer change.
- Reset asserted mid-operation (in PULSE, WAIT, or during debounce):
  - All state clears immediately; `num_clk` drops asynchronously.
  - Queued values are discarded.
  - After release, the next push requires a fresh debounced rising edge.

## Test plan
- Reset and single press (DEBOUNCE = 4): after reset, count = 0, `empty` = 1, `num_clk` = 0; then hold `sw_in` = 8'h2A and `btn` high for 10 cycles → count = 1 at edge 7; with `block` high → one `num_clk` pulse with `num_in` = 8'h2A, then count = 0.
- Bounce rejection: toggle `btn` 1,0,1,0 on single cycles, then hold it high → exactly one push; count = 1; `overflow` = 0.
- Queue ahead, one-per-request: with `block` = 0, press 8'h01, 8'h02, 8'h03; then pulse `block` high for 5 cycles three times → `num_in` shows 01, 02, 03 on successive single-cycle `num_clk` pulses, with no second pulse inside any one `block` window.
- Full and overflow (DEPTH = 4): with `block` = 0, make 5 presses with values 10..14 → `full` = 1, count = 4, `overflow` = 1; drain → values 10, 11, 12, 13; `overflow` stays 1 until reset.
- Simultaneous push and pop while full: arrange a debounced push on the same edge as a PULSE pop → count remains 4 and `overflow` = 0; the new value is delivered last.
- Reset in PULSE: assert `reset` while `num_clk` = 1 → `num_clk` = 0 immediately, count = 0, `num_in` = 0; with `block` still high after release, no pulse occurs until a new press.
